cacheline_adaptor: RTL
======================

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 read_i  input  1  line read request from arbiter, held high until resp_o.
REQ-004 write_i  input  1  line write request from arbiter, held high until resp_o.
REQ-005 address_i  input  32  line address from arbiter.
REQ-006 line_i  input  256  write line from arbiter.
REQ-007 line_o  output  256  read line to arbiter.
REQ-008 resp_o  output  1  one-cycle completion pulse to arbiter.
REQ-009 error_o  output  1  one-cycle error pulse to arbiter, coincident with resp_o.
REQ-010 address_o  output  32  burst address to memory.
REQ-011 read_o  output  1  burst read strobe to memory.
REQ-012 write_o  output  1  burst write strobe to memory.
REQ-013 burst_o  output  64  write beat to memory.
REQ-014 burst_i  input  64  read beat from memory.
REQ-015 resp_i  input  1  memory beat acknowledge, one per beat.
REQ-016 error_i  input  1  memory error, sampled any burst cycle.

Function
REQ-017 SHALL convert one 256-bit line transfer into exactly 4 beats of 64 bits; beat k carries line bits [64k+63:64k], k=0..3.
REQ-018 SHALL implement states IDLE, RBURST, WBURST, DONE, ERR.
REQ-019 IDLE: read_i=1 -> RBURST; else write_i=1 -> WBURST; read wins when both high; address_i and (for write) line_i latched on that edge.
REQ-020 address_o SHALL equal latched address with bits [4:0] forced to 0, stable for the whole burst.
REQ-021 read_o SHALL be 1 exactly in RBURST; write_o exactly in WBURST; never both.
REQ-022 A 2-bit beat counter SHALL reset to 0 on entering a burst and increment on each cycle with resp_i=1.
REQ-023 RBURST: on resp_i=1, burst_i stored into staging slot[counter]; on 4th beat (counter=3) -> DONE.
REQ-024 WBURST: burst_o = latched line slot[counter] combinationally; on 4th beat -> DONE.
REQ-025 resp_i while not in RBURST/WBURST SHALL be ignored.
REQ-026 DONE: resp_o=1 for one cycle; for reads line_o SHALL take staging contents on entering DONE; then -> IDLE unconditionally.
REQ-027 line_o SHALL change only on successful read completion; holds value otherwise, including after errors and writes.
REQ-028 error_i=1 in RBURST/WBURST SHALL abort the burst (beat on that cycle discarded) -> ERR.
REQ-029 ERR: resp_o=1 and error_o=1 for one cycle; then -> IDLE; line_o unchanged.
REQ-030 Requests SHALL NOT be accepted in DONE/ERR; earliest re-acceptance is the IDLE cycle after.
REQ-031 Latency with zero-wait memory: request seen in IDLE at cycle T, read_o/write_o high T+1..T+4, resp_o at T+5.
REQ-032 Memory wait states (resp_i=0) SHALL stall the counter with strobes and address held; no timeout.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, counter=0, read_o=write_o=resp_o=error_o=0, address_o=0, line_o=0, burst_o=0.
REQ-034 Reset mid-burst SHALL abandon the transfer with no resp_o; first request after rst_n rises is handled normally.

Verification
REQ-035 Read, zero wait: read_i, address_i=0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 -> address_o=0x0000_1220, read_o 4 cycles, resp_o at T+5, line_o={0x44..44,0x33..33,0x22..22,0x11..11}.
REQ-036 Write with waits: write_i, line_i={D3,D2,D1,D0}, resp_i on alternate cycles -> burst_o D0,D1,D2,D3 in order each held until ack, write_o 8 cycles, single resp_o.
REQ-037 Simultaneous read_i=write_i=1 -> read burst only, write_o never 1.
REQ-038 error_i on beat 2 of read -> error_o=resp_o=1 one cycle, line_o keeps prior value, next read succeeds.
REQ-039 rst_n pulsed low during WBURST beat 1 -> outputs zero same cycle, no resp_o, following read completes correctly.
REQ-040 Back-to-back reads held high -> exactly one IDLE cycle between resp_o and next read_o.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, 4-beat burst memory port.
// Handles reads, writes, memory wait states and memory error aborts.
module cacheline_adaptor (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         read_i,
    input  logic         write_i,
    input  logic [31:0]  address_i,
    input  logic [255:0] line_i,
    output logic [255:0] line_o,
    output logic         resp_o,
    output logic         error_o,
    output logic [31:0]  address_o,
    output logic         read_o,
    output logic         write_o,
    output logic [63:0]  burst_o,
    input  logic [63:0]  burst_i,
    input  logic         resp_i,
    input  logic         error_i
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RBURST,
        ST_WBURST,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_cnt;
    logic [31:0]    r_addr;
    logic [255:0]   r_wline;
    logic [255:0]   r_line_o;
    logic [63:0]    r_stage [4];
    logic           w_beat_ok;
    logic           w_last;
    logic [7:0]     w_wbeat_lsb;

    // A beat only counts when acknowledged without an error on the same cycle.
    assign w_beat_ok   = resp_i && !error_i;
    assign w_last      = w_beat_ok && (r_cnt == 2'd3);
    assign w_wbeat_lsb = {r_cnt, 6'd0};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (read_i) begin
                    w_next = ST_RBURST;
                end else if (write_i) begin
                    w_next = ST_WBURST;
                end
            end
            ST_RBURST, ST_WBURST: begin
                if (error_i) begin
                    w_next = ST_ERR;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE, ST_ERR: w_next = ST_IDLE;
            default:         w_next = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_addr   <= 32'd0;
            r_wline  <= 256'd0;
            r_line_o <= 256'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 2'd0;
                    if (read_i || write_i) begin
                        r_addr <= address_i;
                    end
                    if (!read_i && write_i) begin
                        r_wline <= line_i;
                    end
                end
                ST_RBURST: begin
                    if (w_beat_ok) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                    // The final beat goes straight into line_o alongside the staged ones.
                    if (w_last) begin
                        r_line_o <= {burst_i, r_stage[2], r_stage[1], r_stage[0]};
                    end
                end
                ST_WBURST: begin
                    if (w_beat_ok) begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: staging storage is not reset; every slot is rewritten before line_o consumes it.
    always_ff @(posedge clk) begin
        if (r_state == ST_RBURST && w_beat_ok) begin
            r_stage[r_cnt] <= burst_i;
        end
    end

    assign read_o    = (r_state == ST_RBURST);
    assign write_o   = (r_state == ST_WBURST);
    assign resp_o    = (r_state == ST_DONE) || (r_state == ST_ERR);
    assign error_o   = (r_state == ST_ERR);
    assign address_o = {r_addr[31:5], 5'd0};
    assign burst_o   = write_o ? r_wline[w_wbeat_lsb +: 64] : 64'd0;
    assign line_o    = r_line_o;

endmodule
